stack_unit: RTL and testbench

Execution-side consumer of fetched instructions that owns the 6502 stack pointer and runs every stack-touching opcode: PHA, PHP, PLA, PLP, JSR (return-address push), RTS, TXS and TSX. It accepts a decoded opcode on the rising edge of instruction_ready and sequences stack reads and writes on the memory port. It returns results to A, P, X or PC and pulses instruction_done to restart the fetch.

---
 rtl/stack_unit.sv | 192 +++++++++++++++++++
 tb/tb_stack_unit.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_unit.sv
// Stack sequencer for the 6502 stack opcodes PHA, PHP, PLA, PLP, JSR, RTS, TXS and TSX.
// Owns the stack pointer, drives the stack memory port and returns results to A, P, X or PC.
module stack_unit #(
  parameter int                    REG_WIDTH  = 8,
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] STACK_BASE = 16'h0100,
  parameter logic [REG_WIDTH-1:0]  SP_RESET   = 8'hFD
) (
  input  logic                  phi1,
  input  logic                  reset_n,
  input  logic                  instruction_ready,
  input  logic [7:0]            opcode,
  input  logic [ADDR_WIDTH-1:0] ret_addr,
  input  logic [REG_WIDTH-1:0]  a_in,
  input  logic [REG_WIDTH-1:0]  p_in,
  input  logic [REG_WIDTH-1:0]  x_in,
  input  logic [REG_WIDTH-1:0]  data_in,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [REG_WIDTH-1:0]  mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [REG_WIDTH-1:0]  sp,
  output logic [REG_WIDTH-1:0]  a_out,
  output logic [REG_WIDTH-1:0]  p_out,
  output logic [REG_WIDTH-1:0]  x_out,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic                  a_we,
  output logic                  p_we,
  output logic                  x_we,
  output logic                  pc_we,
  output logic                  busy,
  output logic                  instruction_done
);

  // state   | meaning
  // IDLE    | waiting for a rising edge of instruction_ready
  // PUSH    | PHA/PHP write at sp, then sp-1
  // PUSH_HI | JSR writes return address high byte, then sp-1
  // PUSH_LO | JSR writes return address low byte, then sp-1
  // INC     | pull pre-increment of sp
  // RD      | read strobe at sp (PLA/PLP data, RTS low byte)
  // INC2    | RTS captures low byte, sp+1
  // RD_HI   | RTS read strobe for high byte
  // WB      | writeback of pulled data to A, P or PC
  // XFER    | TXS loads sp from X, TSX writes sp to X
  // DONE    | one-cycle completion pulse
  typedef enum logic [3:0] {
    IDLE, PUSH, PUSH_HI, PUSH_LO, INC, RD, INC2, RD_HI, WB, XFER, DONE
  } state_t;

  localparam logic [7:0] OP_PHA = 8'h48;
  localparam logic [7:0] OP_PHP = 8'h08;
  localparam logic [7:0] OP_PLA = 8'h68;
  localparam logic [7:0] OP_PLP = 8'h28;
  localparam logic [7:0] OP_JSR = 8'h20;
  localparam logic [7:0] OP_RTS = 8'h60;
  localparam logic [7:0] OP_TXS = 8'h9A;
  localparam logic [7:0] OP_TSX = 8'hBA;

  localparam logic [REG_WIDTH-1:0] SP_ONE     = REG_WIDTH'(1);
  localparam logic [REG_WIDTH-1:0] P_PUSH_SET = REG_WIDTH'(8'h30);
  localparam logic [REG_WIDTH-1:0] P_PULL_CLR = REG_WIDTH'(8'hEF);
  localparam logic [REG_WIDTH-1:0] P_PULL_SET = REG_WIDTH'(8'h20);

  state_t                  state;
  logic                    ready_d;
  logic [7:0]              op_q;
  logic [REG_WIDTH-1:0]    lo_q;
  logic [ADDR_WIDTH-1:0]   stack_addr;
  logic [ADDR_WIDTH-1:0]   pc_next;

  assign stack_addr = STACK_BASE + ADDR_WIDTH'(sp);
  assign pc_next    = ADDR_WIDTH'({data_in, lo_q}) + ADDR_WIDTH'(1);

  always_ff @(posedge phi1 or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      sp      <= SP_RESET;
      ready_d <= 1'b0;
      op_q    <= 8'h00;
      lo_q    <= '0;
    end else begin
      ready_d <= instruction_ready;
      case (state)
        IDLE: begin
          if (instruction_ready && !ready_d) begin
            op_q <= opcode;
            case (opcode)
              OP_PHA, OP_PHP:         state <= PUSH;
              OP_JSR:                 state <= PUSH_HI;
              OP_PLA, OP_PLP, OP_RTS: state <= INC;
              OP_TXS, OP_TSX:         state <= XFER;
              default:                state <= IDLE;
            endcase
          end
        end
        PUSH: begin
          sp    <= sp - SP_ONE;
          state <= DONE;
        end
        PUSH_HI: begin
          sp    <= sp - SP_ONE;
          state <= PUSH_LO;
        end
        PUSH_LO: begin
          sp    <= sp - SP_ONE;
          state <= DONE;
        end
        INC: begin
          sp    <= sp + SP_ONE;
          state <= RD;
        end
        RD:      state <= (op_q == OP_RTS) ? INC2 : WB;
        INC2: begin
          // data_in now holds the byte read in RD
          lo_q  <= data_in;
          sp    <= sp + SP_ONE;
          state <= RD_HI;
        end
        RD_HI:   state <= WB;
        WB:      state <= DONE;
        XFER: begin
          if (op_q == OP_TXS) sp <= x_in;
          state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_addr         = '0;
    mem_wdata        = '0;
    mem_we           = 1'b0;
    mem_re           = 1'b0;
    a_out            = '0;
    p_out            = '0;
    x_out            = '0;
    pc_out           = '0;
    a_we             = 1'b0;
    p_we             = 1'b0;
    x_we             = 1'b0;
    pc_we            = 1'b0;
    instruction_done = 1'b0;
    case (state)
      PUSH: begin
        mem_we    = 1'b1;
        mem_wdata = (op_q == OP_PHP) ? (p_in | P_PUSH_SET) : a_in;
      end
      PUSH_HI: begin
        mem_we    = 1'b1;
        mem_wdata = ret_addr[2*REG_WIDTH-1:REG_WIDTH];
      end
      PUSH_LO: begin
        mem_we    = 1'b1;
        mem_wdata = ret_addr[REG_WIDTH-1:0];
      end
      RD, RD_HI: mem_re = 1'b1;
      WB: begin
        case (op_q)
          OP_PLA: begin
            a_out = data_in;
            a_we  = 1'b1;
          end
          OP_PLP: begin
            // B is not a real flag; the unused bit always reads back set
            p_out = (data_in & P_PULL_CLR) | P_PULL_SET;
            p_we  = 1'b1;
          end
          OP_RTS: begin
            pc_out = pc_next;
            pc_we  = 1'b1;
          end
          default: ;
        endcase
      end
      XFER: begin
        if (op_q == OP_TSX) begin
          x_out = sp;
          x_we  = 1'b1;
        end
      end
      DONE:    instruction_done = 1'b1;
      default: ;
    endcase
    if (mem_we || mem_re) mem_addr = stack_addr;
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_stack_unit.sv
// Bench for stack_unit: table of single-opcode vectors plus hand-written handshake/reset sequences.
// A negedge monitor pops an expected-event scoreboard for every strobe the DUT raises.
module tb_stack_unit;

  localparam logic [2:0] K_WR = 3'd0;
  localparam logic [2:0] K_RD = 3'd1;
  localparam logic [2:0] K_A  = 3'd2;
  localparam logic [2:0] K_P  = 3'd3;
  localparam logic [2:0] K_X  = 3'd4;
  localparam logic [2:0] K_PC = 3'd5;
  localparam logic [2:0] K_DN = 3'd6;

  typedef struct packed {
    logic [2:0]  kind;
    logic [3:0]  cyc;
    logic [15:0] addr;
    logic [15:0] data;
  } ev_t;

  typedef struct {
    logic [7:0]  op, a, p, x;
    logic [15:0] ret;
    int          npk;
    logic [7:0]  pa0, pd0, pa1, pd1;
    logic [7:0]  sp_after;
    int          nev;
    ev_t [3:0]   e;
  } vec_t;

  localparam ev_t NONE = '0;

  logic        phi1;
  logic        reset_n;
  logic        instruction_ready;
  logic [7:0]  opcode;
  logic [15:0] ret_addr;
  logic [7:0]  a_in, p_in, x_in, data_in;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we, mem_re;
  logic [7:0]  sp;
  logic [7:0]  a_out, p_out, x_out;
  logic [15:0] pc_out;
  logic        a_we, p_we, x_we, pc_we;
  logic        busy, instruction_done;

  stack_unit dut (
    .phi1              (phi1),
    .reset_n           (reset_n),
    .instruction_ready (instruction_ready),
    .opcode            (opcode),
    .ret_addr          (ret_addr),
    .a_in              (a_in),
    .p_in              (p_in),
    .x_in              (x_in),
    .data_in           (data_in),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_we            (mem_we),
    .mem_re            (mem_re),
    .sp                (sp),
    .a_out             (a_out),
    .p_out             (p_out),
    .x_out             (x_out),
    .pc_out            (pc_out),
    .a_we              (a_we),
    .p_we              (p_we),
    .x_we              (x_we),
    .pc_we             (pc_we),
    .busy              (busy),
    .instruction_done  (instruction_done)
  );

  initial phi1 = 1'b0;
  always #5 phi1 = ~phi1;

  int cyc = 0;
  always @(posedge phi1) cyc++;

  // Synchronous stack-page memory: read data appears the cycle after mem_re.
  logic [7:0] mem [256];
  logic       poke_en;
  logic [7:0] poke_addr, poke_data;
  always @(posedge phi1) begin
    if (poke_en) mem[poke_addr] <= poke_data;
    if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    data_in <= mem_re ? mem[mem_addr[7:0]] : 8'h00;
  end

  ev_t  exp_q[$];
  vec_t vecs[$];
  int   checks;
  int   errors;
  int   issue_cyc;
  bit   done_seen;

  function automatic ev_t mk_ev(input logic [2:0] k, input int c, input logic [15:0] a,
                                input logic [15:0] d);
    ev_t e;
    e.kind = k;
    e.cyc  = 4'(c);
    e.addr = a;
    e.data = d;
    return e;
  endfunction

  function automatic vec_t mkv(input logic [7:0] op, input logic [7:0] a, input logic [7:0] p,
                               input logic [7:0] x, input logic [15:0] ret, input int npk,
                               input logic [7:0] pa0, input logic [7:0] pd0,
                               input logic [7:0] pa1, input logic [7:0] pd1,
                               input logic [7:0] sp_after, input int nev,
                               input ev_t e0, input ev_t e1, input ev_t e2, input ev_t e3);
    vec_t v;
    v.op = op; v.a = a; v.p = p; v.x = x; v.ret = ret;
    v.npk = npk; v.pa0 = pa0; v.pd0 = pd0; v.pa1 = pa1; v.pd1 = pd1;
    v.sp_after = sp_after; v.nev = nev;
    v.e[0] = e0; v.e[1] = e1; v.e[2] = e2; v.e[3] = e3;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  task automatic obs(input logic [2:0] k, input logic [15:0] a, input logic [15:0] d);
    ev_t e;
    int  off;
    bit  need_a, need_d;
    off = cyc - issue_cyc;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_strobe actual kind %0d cyc %0d addr %h data %h required none",
               k, off, a, d);
      return;
    end
    e = exp_q.pop_front();
    need_a = (k == K_WR) || (k == K_RD);
    need_d = !((k == K_RD) || (k == K_DN));
    if (e.kind !== k || int'(e.cyc) != off || (need_a && e.addr !== a) ||
        (need_d && e.data !== d)) begin
      errors++;
      $display("FAIL event actual kind %0d cyc %0d addr %h data %h required kind %0d cyc %0d addr %h data %h",
               k, off, a, d, e.kind, e.cyc, e.addr, e.data);
    end
  endtask

  task automatic monitor();
    int n;
    forever begin
      @(negedge phi1);
      n = int'(mem_we) + int'(mem_re) + int'(a_we) + int'(p_we) + int'(x_we) +
          int'(pc_we) + int'(instruction_done);
      if (n > 0) begin
        checks++;
        if (n > 1) begin
          errors++;
          $display("FAIL strobe_overlap actual %0d strobes required at most 1", n);
        end
      end
      if (mem_we === 1'b1)           obs(K_WR, mem_addr, {8'h00, mem_wdata});
      if (mem_re === 1'b1)           obs(K_RD, mem_addr, 16'h0000);
      if (a_we === 1'b1)             obs(K_A, 16'h0000, {8'h00, a_out});
      if (p_we === 1'b1)             obs(K_P, 16'h0000, {8'h00, p_out});
      if (x_we === 1'b1)             obs(K_X, 16'h0000, {8'h00, x_out});
      if (pc_we === 1'b1)            obs(K_PC, 16'h0000, pc_out);
      if (instruction_done === 1'b1) begin
        obs(K_DN, 16'h0000, 16'h0000);
        done_seen = 1'b1;
      end
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(posedge phi1); #2;
    poke_addr = a; poke_data = d; poke_en = 1'b1;
    @(posedge phi1); #2;
    poke_en = 1'b0;
  endtask

  task automatic issue(input logic [7:0] op, input logic [7:0] a, input logic [7:0] p,
                       input logic [7:0] x, input logic [15:0] ret, input int hold);
    @(posedge phi1); #2;
    opcode = op; a_in = a; p_in = p; x_in = x; ret_addr = ret;
    done_seen = 1'b0;
    issue_cyc = cyc;
    instruction_ready = 1'b1;
    repeat (hold) @(posedge phi1);
    #2;
    instruction_ready = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (!done_seen && n < limit) begin
      @(posedge phi1);
      n++;
    end
    chk("done_seen", 32'(done_seen), 32'h1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    if (v.npk > 0) poke(v.pa0, v.pd0);
    if (v.npk > 1) poke(v.pa1, v.pd1);
    for (int j = 0; j < v.nev; j++) exp_q.push_back(v.e[j]);
    issue(v.op, v.a, v.p, v.x, v.ret, 1);
    wait_done(12);
    @(posedge phi1); #2;
    chk($sformatf("v%0d_missing_events", idx), exp_q.size(), 0);
    chk($sformatf("v%0d_sp", idx), 32'(sp), 32'(v.sp_after));
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(posedge phi1); #2;
    reset_n = 1'b0;
    instruction_ready = 1'b0;
    repeat (2) @(posedge phi1);
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    checks = 0; errors = 0; issue_cyc = 0; done_seen = 1'b0;
    reset_n = 1'b0; instruction_ready = 1'b0; opcode = 8'h00; ret_addr = 16'h0000;
    a_in = 8'h00; p_in = 8'h00; x_in = 8'h00;
    poke_en = 1'b0; poke_addr = 8'h00; poke_data = 8'h00;

    fork
      monitor();
      begin
        #200000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1);
      end
    join_none

    // op, a, p, x, ret, npk, pa0, pd0, pa1, pd1, sp_after, nev, events
    vecs.push_back(mkv(8'h48, 8'h5A, 8'hC3, 8'h11, 16'h1234, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFC, 2,
      mk_ev(K_WR, 1, 16'h01FD, 16'h005A), mk_ev(K_DN, 2, 16'h0, 16'h0), NONE, NONE));
    vecs.push_back(mkv(8'h68, 8'h00, 8'h00, 8'h00, 16'h0000, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFD, 3,
      mk_ev(K_RD, 2, 16'h01FD, 16'h0), mk_ev(K_A, 3, 16'h0, 16'h005A), mk_ev(K_DN, 4, 16'h0, 16'h0), NONE));
    vecs.push_back(mkv(8'h20, 8'h00, 8'h00, 8'h00, 16'hC012, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFB, 3,
      mk_ev(K_WR, 1, 16'h01FD, 16'h00C0), mk_ev(K_WR, 2, 16'h01FC, 16'h0012), mk_ev(K_DN, 3, 16'h0, 16'h0), NONE));
    vecs.push_back(mkv(8'h60, 8'h00, 8'h00, 8'h00, 16'h0000, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFD, 4,
      mk_ev(K_RD, 2, 16'h01FC, 16'h0), mk_ev(K_RD, 4, 16'h01FD, 16'h0), mk_ev(K_PC, 5, 16'h0, 16'hC013),
      mk_ev(K_DN, 6, 16'h0, 16'h0)));
    vecs.push_back(mkv(8'hBA, 8'h00, 8'h00, 8'h77, 16'h0000, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFD, 2,
      mk_ev(K_X, 1, 16'h0, 16'h00FD), mk_ev(K_DN, 2, 16'h0, 16'h0), NONE, NONE));
    vecs.push_back(mkv(8'h9A, 8'h00, 8'h00, 8'h00, 16'h0000, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1,
      mk_ev(K_DN, 2, 16'h0, 16'h0), NONE, NONE, NONE));
    vecs.push_back(mkv(8'h08, 8'h44, 8'h81, 8'h00, 16'h0000, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 2,
      mk_ev(K_WR, 1, 16'h0100, 16'h00B1), mk_ev(K_DN, 2, 16'h0, 16'h0), NONE, NONE));
    vecs.push_back(mkv(8'h28, 8'h00, 8'h00, 8'h00, 16'h0000, 1, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 3,
      mk_ev(K_RD, 2, 16'h0100, 16'h0), mk_ev(K_P, 3, 16'h0, 16'h00EF), mk_ev(K_DN, 4, 16'h0, 16'h0), NONE));
    vecs.push_back(mkv(8'h60, 8'h00, 8'h00, 8'h00, 16'h0000, 2, 8'h01, 8'hFF, 8'h02, 8'hFF, 8'h02, 4,
      mk_ev(K_RD, 2, 16'h0101, 16'h0), mk_ev(K_RD, 4, 16'h0102, 16'h0), mk_ev(K_PC, 5, 16'h0, 16'h0000),
      mk_ev(K_DN, 6, 16'h0, 16'h0)));
    vecs.push_back(mkv(8'h28, 8'h00, 8'h00, 8'h00, 16'h0000, 1, 8'h03, 8'h10, 8'h00, 8'h00, 8'h03, 3,
      mk_ev(K_RD, 2, 16'h0103, 16'h0), mk_ev(K_P, 3, 16'h0, 16'h0020), mk_ev(K_DN, 4, 16'h0, 16'h0), NONE));
    vecs.push_back(mkv(8'h48, 8'hA7, 8'hFF, 8'h00, 16'h0000, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 2,
      mk_ev(K_WR, 1, 16'h0103, 16'h00A7), mk_ev(K_DN, 2, 16'h0, 16'h0), NONE, NONE));
    vecs.push_back(mkv(8'h08, 8'hFF, 8'h00, 8'h00, 16'h0000, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 2,
      mk_ev(K_WR, 1, 16'h0102, 16'h0030), mk_ev(K_DN, 2, 16'h0, 16'h0), NONE, NONE));
    vecs.push_back(mkv(8'h9A, 8'h00, 8'h00, 8'hFF, 16'h0000, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 1,
      mk_ev(K_DN, 2, 16'h0, 16'h0), NONE, NONE, NONE));
    vecs.push_back(mkv(8'h68, 8'h00, 8'h00, 8'h00, 16'h0000, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3,
      mk_ev(K_RD, 2, 16'h0100, 16'h0), mk_ev(K_A, 3, 16'h0, 16'h00FF), mk_ev(K_DN, 4, 16'h0, 16'h0), NONE));
    vecs.push_back(mkv(8'hBA, 8'h00, 8'h00, 8'h55, 16'h0000, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2,
      mk_ev(K_X, 1, 16'h0, 16'h0000), mk_ev(K_DN, 2, 16'h0, 16'h0), NONE, NONE));

    do_reset();
    chk("rst_sp", 32'(sp), 32'hFD);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(instruction_done), 32'h0);
    chk("rst_mem_strobes", {30'h0, mem_we, mem_re}, 32'h0);
    chk("rst_wb_strobes", {28'h0, a_we, p_we, x_we, pc_we}, 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_data_outs", {a_out, p_out, x_out, mem_wdata}, 32'h0);
    chk("rst_pc_out", 32'(pc_out), 32'h0);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // instruction_ready held high long past DONE executes exactly once
    do_reset();
    exp_q.push_back(mk_ev(K_WR, 1, 16'h01FD, 16'h0033));
    exp_q.push_back(mk_ev(K_DN, 2, 16'h0, 16'h0));
    issue(8'h48, 8'h33, 8'h00, 8'h00, 16'h0000, 10);
    wait_done(12);
    repeat (4) @(posedge phi1);
    #2;
    chk("hold_missing_events", exp_q.size(), 0);
    chk("hold_sp", 32'(sp), 32'hFC);

    // unlisted opcode is ignored
    issue(8'hEA, 8'h99, 8'h00, 8'h00, 16'h0000, 1);
    chk("nop_busy", 32'(busy), 32'h0);
    repeat (6) @(posedge phi1);
    #2;
    chk("nop_done", 32'(done_seen), 32'h0);
    chk("nop_sp", 32'(sp), 32'hFC);

    // a fresh ready edge while busy is dropped
    exp_q.push_back(mk_ev(K_RD, 2, 16'h01FD, 16'h0));
    exp_q.push_back(mk_ev(K_A, 3, 16'h0, 16'h0033));
    exp_q.push_back(mk_ev(K_DN, 4, 16'h0, 16'h0));
    issue(8'h68, 8'h00, 8'h00, 8'h00, 16'h0000, 1);
    @(posedge phi1); #2;
    opcode = 8'h48;
    instruction_ready = 1'b1;
    chk("busy_edge_busy", 32'(busy), 32'h1);
    wait_done(12);
    repeat (3) @(posedge phi1);
    #2;
    instruction_ready = 1'b0;
    repeat (3) @(posedge phi1);
    #2;
    chk("busy_edge_missing_events", exp_q.size(), 0);
    chk("busy_edge_sp", 32'(sp), 32'hFD);

    // reset during RTS high-byte read abandons the sequence
    exp_q.push_back(mk_ev(K_RD, 2, 16'h01FE, 16'h0));
    issue(8'h60, 8'h00, 8'h00, 8'h00, 16'h0000, 1);
    while (cyc < issue_cyc + 4) begin
      @(posedge phi1);
      #1;
    end
    #1;
    chk("midrst_in_rd_hi", {15'h0, mem_re, mem_addr}, 32'h0001_01FF);
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_sp", 32'(sp), 32'hFD);
    chk("midrst_mem_re", 32'(mem_re), 32'h0);
    repeat (2) @(posedge phi1);
    #2;
    reset_n = 1'b1;
    repeat (6) @(posedge phi1);
    #2;
    chk("midrst_no_done", 32'(done_seen), 32'h0);
    chk("midrst_missing_events", exp_q.size(), 0);
    chk("midrst_sp_after", 32'(sp), 32'hFD);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
